// File: rtl/fifo_bcd_reader.sv
// Reads one word from a FIFO per request and converts it to hundreds/tens/ones BCD digits.
// Optional macro FBR_AUTO_EN lets the auto input drain the FIFO continuously.
module fifo_bcd_reader #(
   parameter int WL          = 8,
   parameter int DL          = 4,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          step,
   input  logic          auto,
   input  logic          empty,
   input  logic [WL-1:0] dout,
   output logic          rReq,
   output logic [DL-1:0] ones,
   output logic [DL-1:0] ten,
   output logic [DL-1:0] hund,
   output logic          done,
   output logic          busy,
   output logic          underrun
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      CAPT = 3'd2,
      CONV = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t          state_q;
   logic            step_q;
   logic [WL-1:0]   sh_q;
   logic [11:0]     bcd_q;
   logic [3:0]      bit_q;
   logic [HW-1:0]   hold_q;
   logic            rreq_q;
   logic            done_q;
   logic            busy_q;
   logic            under_q;
   logic [DL-1:0]   ones_q;
   logic [DL-1:0]   ten_q;
   logic [DL-1:0]   hund_q;

   logic            step_edge_s;
   logic            auto_en_s;
   logic            go_s;
   logic [11:0]     bcd_d;

   // Add 3 to every scratch digit that is 5 or more, ahead of the next left shift.
   function automatic logic [11:0] add3_digits(input logic [11:0] bcd);
      logic [11:0] res;
      res = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end else begin
            res[4*i +: 4] = bcd[4*i +: 4];
         end
      end
      return res;
   endfunction

`ifdef FBR_AUTO_EN
   assign auto_en_s = auto;
`else
   assign auto_en_s = auto & 1'b0;
`endif

   // Start decision and the next double-dabble scratch value.
   always_comb begin
      step_edge_s = step & ~step_q;
      go_s        = ~empty & (step_edge_s | auto_en_s);
      bcd_d       = (add3_digits(bcd_q) << 1) | {11'd0, sh_q[WL-1]};
   end

   // Read/convert/hold sequencer with all outputs held in registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         step_q  <= 1'b0;
         sh_q    <= '0;
         bcd_q   <= 12'd0;
         bit_q   <= 4'd0;
         hold_q  <= '0;
         rreq_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         under_q <= 1'b0;
         ones_q  <= '0;
         ten_q   <= '0;
         hund_q  <= '0;
      end else begin
         step_q <= step;
         rreq_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go_s) begin
                  state_q <= REQ;
                  rreq_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (step_edge_s) begin
                  under_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            REQ: begin
               state_q <= CAPT;
            end
            CAPT: begin
               sh_q    <= dout;
               bcd_q   <= 12'd0;
               bit_q   <= 4'd0;
               state_q <= CONV;
            end
            CONV: begin
               sh_q  <= sh_q << 1;
               bcd_q <= bcd_d;
               bit_q <= bit_q + 4'd1;
               // Last bit: the digits and done land together, first cycle of HOLD.
               if (bit_q == 4'(WL - 1)) begin
                  ones_q  <= DL'(bcd_d[3:0]);
                  ten_q   <= DL'(bcd_d[7:4]);
                  hund_q  <= DL'(bcd_d[11:8]);
                  done_q  <= 1'b1;
                  hold_q  <= '0;
                  state_q <= HOLD;
               end else begin
                  state_q <= CONV;
               end
            end
            HOLD: begin
               if (hold_q == HW'(HOLD_CYCLES)) begin
                  hold_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rReq     = rreq_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign underrun = under_q;
   assign ones     = ones_q;
   assign ten      = ten_q;
   assign hund     = hund_q;
endmodule

// File: tb/tb_fifo_bcd_reader.sv
// Randomised bench for fifo_bcd_reader against a timeline model of each read (WL=8, HOLD_CYCLES=4).
module tb_fifo_bcd_reader;
   localparam int WL     = 8;
   localparam int DL     = 4;
   localparam int HOLD   = 4;
   localparam int PERIOD = 4 + WL + HOLD;
`ifdef FBR_AUTO_EN
   localparam bit AUTO_ON = 1'b1;
`else
   localparam bit AUTO_ON = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST, step, auto, empty;
   logic [WL-1:0] dout;
   logic          rReq, done, busy, underrun;
   logic [DL-1:0] ones, ten, hund;

   fifo_bcd_reader #(.WL(WL), .DL(DL), .HOLD_CYCLES(HOLD)) dut (
      .CLK(CLK), .RST(RST), .step(step), .auto(auto), .empty(empty), .dout(dout),
      .rReq(rReq), .ones(ones), .ten(ten), .hund(hund),
      .done(done), .busy(busy), .underrun(underrun)
   );

   always #5 CLK = ~CLK;

   int checks = 0, failures = 0;
   int fifo[$];
   int k = 0, start = -1, m_word = 0;
   bit prev_step = 1'b0, m_under = 1'b0;
   int m_ones = 0, m_ten = 0, m_hund = 0;
   bit e_rreq = 1'b0, e_done = 1'b0, e_busy = 1'b0;
   int rreq_cnt = 0, done_cnt = 0, last_rreq = 0, last_done = 0;
   int done_cyc[$];
   int done_val[$];

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, exp, k);
      end
   endtask

   // Model: a read started in cycle s strobes at s+1, shows digits at s+3+WL, frees IDLE at s+PERIOD.
   task automatic model_edge();
      bit edg, idle;
      if (RST) begin
         start = -1; prev_step = 1'b0; m_under = 1'b0;
         m_ones = 0; m_ten = 0; m_hund = 0;
      end else begin
         edg = step && !prev_step;
         prev_step = step;
         idle = (start < 0) || (k >= start + PERIOD);
         if (idle) begin
            if (!empty && (edg || (AUTO_ON && auto))) begin
               start = k;
               m_word = fifo[0];
            end else if (edg && empty) begin
               m_under = 1'b1;
            end
         end
         if (start >= 0 && k + 1 == start + 3 + WL) begin
            m_ones = m_word % 10; m_ten = (m_word / 10) % 10; m_hund = m_word / 100;
         end
      end
      e_rreq = (start >= 0) && (k + 1 == start + 1);
      e_done = (start >= 0) && (k + 1 == start + 3 + WL);
      e_busy = (start >= 0) && (k + 1 >= start + 1) && (k + 1 < start + PERIOD);
      k++;
   endtask

   task automatic tick(int n);
      for (int i = 0; i < n; i++) begin
         model_edge();
         @(negedge CLK);
         chk("rReq", int'(rReq), int'(e_rreq));
         chk("done", int'(done), int'(e_done));
         chk("busy", int'(busy), int'(e_busy));
         chk("underrun", int'(underrun), int'(m_under));
         chk("ones", int'(ones), m_ones);
         chk("ten", int'(ten), m_ten);
         chk("hund", int'(hund), m_hund);
         if (rReq) begin
            rreq_cnt++; last_rreq = k;
            chk("pop_nonempty", int'(fifo.size() > 0), 1);
            if (fifo.size() > 0) dout = WL'(fifo.pop_front());
         end
         if (done) begin
            done_cnt++; last_done = k;
            done_cyc.push_back(k);
            done_val.push_back(int'(hund) * 100 + int'(ten) * 10 + int'(ones));
         end
         empty = (fifo.size() == 0);
      end
   endtask

   task automatic push(int v);
      fifo.push_back(v);
      empty = 1'b0;
   endtask

   task automatic pulse();
      step = 1'b1; tick(1);
      step = 1'b0;
   endtask

   int r0, d0;

   initial begin
      RST = 1'b1; step = 1'b0; auto = 1'b0; empty = 1'b1; dout = '0;
      tick(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_digits", int'(hund) * 100 + int'(ten) * 10 + int'(ones), 0);
      RST = 1'b0;
      tick(2);

      // Single word 237
      r0 = rreq_cnt;
      push(237); pulse(); tick(20);
      chk("w237_hund", int'(hund), 2);
      chk("w237_ten", int'(ten), 3);
      chk("w237_ones", int'(ones), 7);
      chk("w237_done_gap", last_done - last_rreq, 10);
      chk("w237_rreq_cnt", rreq_cnt - r0, 1);

      // 255 then 0
      r0 = rreq_cnt;
      push(255); push(0);
      pulse(); tick(18);
      chk("w255_digits", int'(hund) * 100 + int'(ten) * 10 + int'(ones), 255);
      pulse(); tick(18);
      chk("w0_digits", int'(hund) * 100 + int'(ten) * 10 + int'(ones), 0);
      chk("two_rreq", rreq_cnt - r0, 2);

      // Step toggles during CONV are dropped
      r0 = rreq_cnt; d0 = done_cnt;
      push(100); push(42);
      pulse(); tick(3);
      for (int t = 0; t < 3; t++) begin
         step = 1'b1; tick(1); chk("conv_busy", int'(busy), 1);
         step = 1'b0; tick(1); chk("conv_busy", int'(busy), 1);
      end
      tick(14);
      chk("toggle_rreq", rreq_cnt - r0, 1);
      chk("toggle_done", done_cnt - d0, 1);
      chk("toggle_left", fifo.size(), 1);
      pulse(); tick(18);
      chk("w42_digits", int'(hund) * 100 + int'(ten) * 10 + int'(ones), 42);

      // Underrun on empty
      r0 = rreq_cnt;
      pulse(); tick(5);
      chk("under_set", int'(underrun), 1);
      tick(10);
      chk("under_hold", int'(underrun), 1);
      chk("under_no_rreq", rreq_cnt - r0, 0);
      RST = 1'b1; tick(1); RST = 1'b0; tick(1);
      chk("under_clear", int'(underrun), 0);

      // Auto drain
      r0 = rreq_cnt;
      done_cyc.delete(); done_val.delete();
      push(12); push(99); push(100);
      auto = 1'b1; tick(60); auto = 1'b0;
`ifdef FBR_AUTO_EN
      chk("auto_rreq", rreq_cnt - r0, 3);
      chk("auto_dones", done_cyc.size(), 3);
      if (done_cyc.size() == 3) begin
         chk("auto_v0", done_val[0], 12);
         chk("auto_v1", done_val[1], 99);
         chk("auto_v2", done_val[2], 100);
         chk("auto_gap1", done_cyc[1] - done_cyc[0], 16);
         chk("auto_gap2", done_cyc[2] - done_cyc[1], 16);
      end
      chk("auto_under", int'(underrun), 0);
`else
      chk("auto_ignored", rreq_cnt - r0, 0);
      for (int t = 0; t < 3; t++) begin
         pulse(); tick(17);
      end
      chk("manual_drain", fifo.size(), 0);
`endif

      // Reset in the 4th CONV cycle of 150
      d0 = done_cnt;
      RST = 1'b1; tick(1); RST = 1'b0; tick(1);
      push(150); pulse(); tick(5);
      RST = 1'b1; tick(1);
      chk("rst_conv_busy", int'(busy), 0);
      chk("rst_conv_rreq", int'(rReq), 0);
      RST = 1'b0; tick(15);
      chk("rst_conv_done", done_cnt - d0, 0);
      chk("rst_conv_digits", int'(hund) * 100 + int'(ten) * 10 + int'(ones), 0);
      fifo.delete(); empty = 1'b1;

      // Random traffic
      for (int it = 0; it < 1500; it++) begin
         step = ($urandom_range(0, 3) == 0);
         auto = ($urandom_range(0, 7) == 0);
         RST  = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 9) == 0) push(int'($urandom_range(0, 255)));
         tick(1);
      end
      RST = 1'b0; step = 1'b0; auto = 1'b0;
      tick(PERIOD + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
